frog_input_scheduler: RTL and testbench

- Sits between the keycode register exported by the Nios II and the three frog instances.
- Arbitrates the single arrow-key stream to exactly one active frog and handles frog-select keys.
- Converts raw key levels into frame-aligned move commands with hold-to-repeat, and skips frogs that are dead or already home.
- Replaces the free-running keycode decode in the top level; the frog modules consume one-frame-wide move levels.

---
 rtl/frog_input_scheduler.sv | 219 +++++++++++++++++++++
 tb/tb_frog_input_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_input_scheduler.sv
// frog_input_scheduler: routes the single USB arrow-key stream to one active frog
// and turns held keys into frame-aligned, one-frame-wide move levels with auto-repeat.
module frog_input_scheduler #(
    parameter logic [15:0] KEY_LEFT     = 16'h0050,
    parameter logic [15:0] KEY_RIGHT    = 16'h004F,
    parameter logic [15:0] KEY_UP       = 16'h0052,
    parameter logic [15:0] KEY_DOWN     = 16'h0051,
    parameter logic [15:0] KEY_SEL1     = 16'h0059,
    parameter logic [15:0] KEY_SEL2     = 16'h005A,
    parameter logic [15:0] KEY_SEL3     = 16'h005B,
    parameter int          REPEAT_DELAY = 20,
    parameter int          REPEAT_RATE  = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic [2:0]  frog_unavail,
    input  logic        game_over,
    output logic [1:0]  frog_sel,
    output logic [2:0]  frog_active,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic        frame_tick
);

    // state | meaning
    // IDLE  | no move pending; waits for a fresh arrow press
    // ARMED | arrow latched; first move fires on a frame_tick
    // HOLD  | move issued; counting frames towards the next auto-repeat
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;

    localparam logic [5:0] DELAY_LD = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LD  = 6'(REPEAT_RATE);

    logic        fc_s1, fc_s2, fc_s3;
    logic [15:0] kc_q;
    logic        kc_live, armable;
    state_t      state, state_n;
    logic [5:0]  cnt, cnt_n, cnt_dec;
    logic [1:0]  dir_q, dir_n, kc_dir;
    logic [3:0]  move_q, move_n, dir_hot;
    logic [1:0]  sel_n, sel_key, sel_next_av;
    logic [2:0]  avail;
    logic        kc_arrow, relatch, cur_lost, key_ok, force_idle;

    // armable is low until a non-arrow code has been seen, so a key held
    // through reset or a selection change needs a release and re-press.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fc_s1      <= 1'b0;
            fc_s2      <= 1'b0;
            fc_s3      <= 1'b0;
            frame_tick <= 1'b0;
            kc_q       <= 16'h0000;
            kc_live    <= 1'b0;
            armable    <= 1'b0;
        end else begin
            fc_s1      <= frame_clk;
            fc_s2      <= fc_s1;
            fc_s3      <= fc_s2;
            frame_tick <= fc_s2 & ~fc_s3;
            kc_q       <= keycode;
            kc_live    <= 1'b1;
            armable    <= kc_live & ~kc_arrow;
        end
    end

    always_comb begin
        kc_arrow = 1'b1;
        kc_dir   = 2'd0;
        case (kc_q)
            KEY_UP:    kc_dir = 2'd0;
            KEY_DOWN:  kc_dir = 2'd1;
            KEY_LEFT:  kc_dir = 2'd2;
            KEY_RIGHT: kc_dir = 2'd3;
            default:   kc_arrow = 1'b0;
        endcase
    end

    always_comb begin
        sel_key = 2'd0;
        case (kc_q)
            KEY_SEL1: sel_key = 2'd1;
            KEY_SEL2: sel_key = 2'd2;
            KEY_SEL3: sel_key = 2'd3;
            default:  sel_key = 2'd0;
        endcase
    end

    assign avail = ~frog_unavail;

    // Losing the current frog outranks a same-cycle select key.
    always_comb begin
        cur_lost    = 1'b0;
        sel_next_av = 2'd0;
        case (frog_sel)
            2'd1: begin
                cur_lost    = frog_unavail[0];
                sel_next_av = avail[1] ? 2'd2 : (avail[2] ? 2'd3 : 2'd0);
            end
            2'd2: begin
                cur_lost    = frog_unavail[1];
                sel_next_av = avail[2] ? 2'd3 : (avail[0] ? 2'd1 : 2'd0);
            end
            2'd3: begin
                cur_lost    = frog_unavail[2];
                sel_next_av = avail[0] ? 2'd1 : (avail[1] ? 2'd2 : 2'd0);
            end
            default: begin end
        endcase
        key_ok = 1'b0;
        case (sel_key)
            2'd1:    key_ok = avail[0];
            2'd2:    key_ok = avail[1];
            2'd3:    key_ok = avail[2];
            default: key_ok = 1'b0;
        endcase
        sel_n = frog_sel;
        if (!game_over) begin
            if (cur_lost)
                sel_n = sel_next_av;
            else if (key_ok)
                sel_n = sel_key;
        end
    end

    assign dir_hot    = 4'b0001 << dir_q;
    assign cnt_dec    = (cnt == 6'd0) ? 6'd0 : cnt - 6'd1;
    assign relatch    = kc_arrow && (kc_dir != dir_q);
    assign force_idle = game_over | (frog_sel == 2'd0) | (sel_n != frog_sel);

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        cnt_n   = cnt;
        move_n  = move_q;
        if (force_idle) begin
            state_n = IDLE;
            move_n  = 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick)
                        move_n = 4'b0000;
                    if (kc_arrow && armable) begin
                        dir_n   = kc_dir;
                        state_n = ARMED;
                    end
                end
                // A release while armed still commits the move, so a short tap
                // between ticks yields one pulse; a still-active level gets a gap frame.
                ARMED: begin
                    if (relatch)
                        dir_n = kc_dir;
                    if (frame_tick) begin
                        if (move_q != 4'b0000 || relatch) begin
                            move_n = 4'b0000;
                        end else begin
                            move_n  = dir_hot;
                            cnt_n   = DELAY_LD;
                            state_n = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!kc_arrow) begin
                        state_n = IDLE;
                        if (frame_tick)
                            move_n = 4'b0000;
                    end else if (relatch) begin
                        dir_n   = kc_dir;
                        state_n = ARMED;
                        if (frame_tick)
                            move_n = 4'b0000;
                    end else if (frame_tick) begin
                        cnt_n  = cnt_dec;
                        move_n = 4'b0000;
                        if (cnt_dec == 6'd0) begin
                            move_n = dir_hot;
                            cnt_n  = RATE_LD;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            dir_q    <= 2'd0;
            move_q   <= 4'b0000;
            frog_sel <= 2'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dir_q    <= dir_n;
            move_q   <= move_n;
            frog_sel <= sel_n;
        end
    end

    always_comb begin
        case (frog_sel)
            2'd1:    frog_active = 3'b001;
            2'd2:    frog_active = 3'b010;
            2'd3:    frog_active = 3'b100;
            default: frog_active = 3'b000;
        endcase
    end

    assign {right, left, down, up} = move_q;

endmodule

// File: tb/tb_frog_input_scheduler.sv
// Directed bench for frog_input_scheduler: a selection vector table plus
// hand-written frame sequences for repeat timing, direction change, tap, game over and reset.
module tb_frog_input_scheduler;

    logic        Clk;
    logic        Reset;
    logic        frame_clk;
    logic [15:0] keycode;
    logic [2:0]  frog_unavail;
    logic        game_over;
    logic [1:0]  frog_sel;
    logic [2:0]  frog_active;
    logic        up, down, left, right, frame_tick;

    int n_chk = 0;
    int n_fail = 0;
    int n_frames = 0;
    int ticks_seen = 0;

    frog_input_scheduler dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .frog_unavail (frog_unavail),
        .game_over    (game_over),
        .frog_sel     (frog_sel),
        .frog_active  (frog_active),
        .up           (up),
        .down         (down),
        .left         (left),
        .right        (right),
        .frame_tick   (frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] kc;
        logic [2:0]  unav;
        logic        go;
        int          ncyc;
        logic [1:0]  sel;
        logic [2:0]  act;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    localparam logic [3:0] M_NONE  = 4'b0000;
    localparam logic [3:0] M_UP    = 4'b0001;
    localparam logic [3:0] M_DOWN  = 4'b0010;
    localparam logic [3:0] M_LEFT  = 4'b0100;
    localparam logic [3:0] M_RIGHT = 4'b1000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    function automatic logic [3:0] moves();
        return {right, left, down, up};
    endfunction

    // One frame: 20 Clk with frame_clk high, 20 low; moves sampled after the tick.
    task automatic run_frame(output logic [3:0] mv);
        int t;
        t = 0;
        mv = 4'bxxxx;
        frame_clk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (frame_tick) t++;
            if (i == 7) mv = moves();
        end
        frame_clk = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk);
            #1;
            if (frame_tick) t++;
        end
        n_frames++;
        ticks_seen += t;
    endtask

    task automatic frame_chk(input string name, input logic [3:0] exp);
        logic [3:0] mv;
        run_frame(mv);
        chk(name, mv, exp);
    endtask

    initial begin
        logic [3:0] exp_mv;

        vecs[0]  = '{16'h0000, 3'b000, 1'b0, 2, 2'd0, 3'b000};
        vecs[1]  = '{16'h005A, 3'b000, 1'b0, 2, 2'd2, 3'b010};
        vecs[2]  = '{16'h0000, 3'b001, 1'b0, 2, 2'd2, 3'b010};
        vecs[3]  = '{16'h0059, 3'b001, 1'b0, 2, 2'd2, 3'b010};
        vecs[4]  = '{16'h005B, 3'b001, 1'b0, 2, 2'd3, 3'b100};
        vecs[5]  = '{16'h0000, 3'b101, 1'b0, 2, 2'd2, 3'b010};
        vecs[6]  = '{16'h005B, 3'b111, 1'b0, 2, 2'd0, 3'b000};
        vecs[7]  = '{16'h005A, 3'b111, 1'b0, 2, 2'd0, 3'b000};
        vecs[8]  = '{16'h0000, 3'b111, 1'b0, 2, 2'd0, 3'b000};
        vecs[9]  = '{16'h0000, 3'b000, 1'b0, 2, 2'd0, 3'b000};
        vecs[10] = '{16'h0059, 3'b000, 1'b0, 2, 2'd1, 3'b001};
        vecs[11] = '{16'h005B, 3'b000, 1'b1, 2, 2'd1, 3'b001};
        vecs[12] = '{16'h005B, 3'b001, 1'b0, 1, 2'd2, 3'b010};
        vecs[13] = '{16'h005B, 3'b001, 1'b0, 2, 2'd3, 3'b100};
        vecs[14] = '{16'h0000, 3'b001, 1'b1, 2, 2'd3, 3'b100};
        vecs[15] = '{16'h0000, 3'b100, 1'b1, 2, 2'd3, 3'b100};
        vecs[16] = '{16'h0000, 3'b100, 1'b0, 2, 2'd1, 3'b001};
        vecs[17] = '{16'h1234, 3'b000, 1'b0, 2, 2'd1, 3'b001};

        Reset = 1'b1;
        frame_clk = 1'b0;
        keycode = 16'h0000;
        frog_unavail = 3'b000;
        game_over = 1'b0;
        cycles(3);
        chk("rst_sel", frog_sel, 2'd0);
        chk("rst_active", frog_active, 3'b000);
        chk("rst_moves", moves(), M_NONE);
        chk("rst_tick", frame_tick, 1'b0);
        Reset = 1'b0;
        cycles(3);

        // frame_tick latency: high only after the third edge following the rise
        frame_clk = 1'b1;
        cycles(2);
        chk("tick_lat2", frame_tick, 1'b0);
        cycles(1);
        chk("tick_lat3", frame_tick, 1'b1);
        cycles(1);
        chk("tick_width", frame_tick, 1'b0);
        frame_clk = 1'b0;
        cycles(10);

        for (int i = 0; i < NV; i++) begin
            keycode      = vecs[i].kc;
            frog_unavail = vecs[i].unav;
            game_over    = vecs[i].go;
            cycles(vecs[i].ncyc);
            chk($sformatf("sel_v%0d", i), frog_sel, vecs[i].sel);
            chk($sformatf("act_v%0d", i), frog_active, vecs[i].act);
            chk($sformatf("mv_v%0d", i), moves(), M_NONE);
        end

        // Select frog 2 right after reset, then hold up: moves at frames 1, 21, 29, 37
        keycode = 16'h0000;
        frog_unavail = 3'b000;
        game_over = 1'b0;
        cycles(2);
        Reset = 1'b1;
        cycles(2);
        Reset = 1'b0;
        keycode = 16'h005A;
        cycles(2);
        chk("a_sel", frog_sel, 2'd2);
        chk("a_active", frog_active, 3'b010);
        keycode = 16'h0052;
        cycles(3);
        chk("a_armed_quiet", moves(), M_NONE);
        for (int f = 1; f <= 37; f++) begin
            exp_mv = (f == 1 || f == 21 || f == 29 || f == 37) ? M_UP : M_NONE;
            frame_chk($sformatf("a_rep_f%0d", f), exp_mv);
        end

        // Switch to left during an active up frame
        keycode = 16'h0050;
        frame_chk("b_up_clear", M_NONE);
        frame_chk("b_left", M_LEFT);
        frame_chk("b_left_end", M_NONE);

        // Release, then tap down for 100 Clk between ticks
        keycode = 16'h0000;
        frame_chk("c_release", M_NONE);
        keycode = 16'h0051;
        cycles(100);
        keycode = 16'h0000;
        cycles(3);
        frame_chk("c_tap", M_DOWN);
        frame_chk("c_tap_end", M_NONE);
        frame_chk("c_idle", M_NONE);

        // Game over while right is active
        keycode = 16'h004F;
        cycles(3);
        frame_clk = 1'b1;
        cycles(8);
        chk("d_right", moves(), M_RIGHT);
        game_over = 1'b1;
        cycles(1);
        chk("d_go_clear", moves(), M_NONE);
        keycode = 16'h005B;
        cycles(3);
        chk("d_go_frozen", frog_sel, 2'd2);
        frame_clk = 1'b0;
        cycles(20);
        keycode = 16'h0000;
        cycles(3);
        game_over = 1'b0;
        cycles(3);
        chk("d_sel_after", frog_sel, 2'd2);

        // Reset asserted asynchronously during the first repeat frame
        keycode = 16'h0052;
        cycles(3);
        frame_chk("e_f1", M_UP);
        for (int f = 2; f <= 20; f++)
            frame_chk($sformatf("e_f%0d", f), M_NONE);
        frame_clk = 1'b1;
        cycles(8);
        chk("e_rep_up", moves(), M_UP);
        #3 Reset = 1'b1;
        #1;
        chk("e_async_moves", moves(), M_NONE);
        chk("e_async_sel", frog_sel, 2'd0);
        chk("e_async_active", frog_active, 3'b000);
        frame_clk = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b0;
        cycles(20);
        frame_chk("e_held_f1", M_NONE);
        frame_chk("e_held_f2", M_NONE);
        keycode = 16'h005A;
        cycles(3);
        chk("e_resel", frog_sel, 2'd2);
        keycode = 16'h0052;
        cycles(3);
        frame_chk("e_repress", M_UP);

        // Current frog dies while up is held and active: reselect, no move until re-press
        frog_unavail = 3'b010;
        cycles(2);
        chk("f_sel", frog_sel, 2'd3);
        chk("f_clear", moves(), M_NONE);
        frame_chk("f_held_f1", M_NONE);
        frame_chk("f_held_f2", M_NONE);
        keycode = 16'h0000;
        cycles(3);
        keycode = 16'h0052;
        cycles(3);
        frame_chk("f_repress", M_UP);

        chk("tick_per_frame", ticks_seen, n_frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
